reg_dump_unit: RTL

Debug readout engine downstream of the MIPS register bank's asynchronous debug port. On a start request it freezes the CPU, walks the debug read address over all 32 registers, and streams each 32-bit value as four bytes, MSB first, over a valid/ready byte interface to the UART transmitter. It gives the debug host a consistent snapshot of the architectural register file.

---
 rtl/reg_dump_unit_pkg.sv | 16 +
 rtl/reg_dump_unit_word_serializer.sv | 39 +++
 rtl/reg_dump_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_dump_unit_pkg.sv
// Shared types and sizing for the register dump engine.
package reg_dump_unit_pkg;

    localparam int NUM_REGS      = 32;
    localparam int BYTES_PER_REG = 4;
    localparam int ADDR_W        = 5;
    localparam int WORD_W        = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/reg_dump_unit_word_serializer.sv
// Serializes one 32-bit word into four bytes, MSB first, over valid/ready.
module word_serializer
    import reg_dump_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              send,
    input  logic              ready,
    output logic [7:0]        data,
    output logic              valid,
    output logic              last
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_REG - 1);

    logic [WORD_W-1:0] shift;
    logic [1:0]        byte_cnt;

    // Counter wraps back to 0 after the last byte, so it rests at 0 between words.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shift    <= word;
            byte_cnt <= '0;
        end else if (send && ready) begin
            shift    <= {shift[WORD_W-9:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign valid = send;
    assign data  = shift[WORD_W-1 -: 8];
    assign last  = (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/reg_dump_unit.sv
// Freezes the CPU and streams all architectural registers as bytes to the UART.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addrAsync,
    input  logic [WORD_W-1:0] regData,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady,
    output logic              haltCpu,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              load, send, last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        load      = 1'b0;
        send      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                send = 1'b1;
                if (txReady && last) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            DONE: begin
                addr_nxt  = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    word_serializer u_ser (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .word  (regData),
        .send  (send),
        .ready (txReady),
        .data  (txData),
        .valid (txValid),
        .last  (last)
    );

    // The bank's write port is gated by haltCpu, so the whole non-idle window must stall.
    assign addrAsync = addr;
    assign haltCpu   = (state != IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
